// File: rtl/div_pkg.sv
// Purpose: shared widths, FSM state encoding and the bit-length helper for the
//          divider job issuer.
// Contents: DIV_W   - operand width presented to the divider
//           LEN_W   - width of the m/n bit-length fields
//           OPW_MAX - widest input operand the bit-length helper accepts
//           state_t - issuer FSM states
//           bitlen  - index of the most significant one plus one, 0 for zero
package div_pkg;

    localparam int unsigned DIV_W   = 33;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned OPW_MAX = 31;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DROP = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // Highest set bit wins because later iterations overwrite earlier ones.
    function automatic logic [LEN_W-1:0] bitlen(input logic [OPW_MAX-1:0] x);
        logic [LEN_W-1:0] len;
        len = '0;
        for (int i = 0; i < int'(OPW_MAX); i++) begin
            if (x[i]) begin
                len = LEN_W'(i + 1);
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/div_job_issuer_fifo.sv
// Purpose: show-ahead synchronous FIFO holding packed division jobs.
// Ports:   clk, rst_n      - clock, asynchronous active-low reset
//          push / wdata    - write one entry (ignored when full)
//          pop  / rdata    - rdata is the head entry; pop removes it (ignored when empty)
//          full, empty     - occupancy flags
//          count           - number of stored entries
module job_fifo #(
    parameter int unsigned W     = 72,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rd_ptr];

    assign w_wr = push & ~full;
    assign w_rd = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/div_job_issuer.sv
// Purpose: buffers unsigned division jobs, computes operand bit-lengths on the
//          push side and issues jobs one at a time to the iterative divider.
//          Divide-by-zero jobs are dropped here and flagged with err_div0.
// Ports:   clk, rst_n                 - clock, asynchronous active-low reset
//          in_valid, in_dividend,
//          in_divisor, in_ready       - job input handshake
//          err_div0                   - 1-cycle pulse after a dropped divisor==0 job
//          dividend, divisor, m, n    - job presented to the divider, held while in flight
//          ready                      - 1-cycle start strobe to the divider
//          done                       - divider idle flag (high = idle)
//          count                      - FIFO occupancy
//          jobs_issued                - wrapping count of start strobes
module div_job_issuer
    import div_pkg::*;
#(
    parameter int unsigned OPW   = 31,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [OPW-1:0]            in_dividend,
    input  logic [OPW-1:0]            in_divisor,
    output logic                      in_ready,
    output logic                      err_div0,
    output logic [DIV_W-1:0]          dividend,
    output logic [DIV_W-1:0]          divisor,
    output logic [LEN_W-1:0]          m,
    output logic [LEN_W-1:0]          n,
    output logic                      ready,
    input  logic                      done,
    output logic [$clog2(DEPTH):0]    count,
    output logic [15:0]               jobs_issued
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned JOB_W = 2 * OPW + 2 * LEN_W;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_err_div0;
    logic [DIV_W-1:0] r_dividend;
    logic [DIV_W-1:0] r_divisor;
    logic [LEN_W-1:0] r_m;
    logic [LEN_W-1:0] r_n;
    logic             r_ready;
    logic [15:0]      r_jobs;

    logic             w_accept;
    logic             w_div0;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [LEN_W-1:0] w_len_dd;
    logic [LEN_W-1:0] w_len_ds;
    logic [LEN_W-1:0] w_m;
    logic [JOB_W-1:0] w_wdata;
    logic [JOB_W-1:0] w_rdata;
    logic [OPW-1:0]   w_rd_dd;
    logic [OPW-1:0]   w_rd_ds;
    logic [LEN_W-1:0] w_rd_m;
    logic [LEN_W-1:0] w_rd_n;

    // Push side: accept, filter divide-by-zero, compute bit-lengths.
    assign w_accept = in_valid & r_in_ready;
    assign w_div0   = w_accept & (in_divisor == '0);
    assign w_push   = w_accept & ~w_div0 & ~w_full;

    assign w_len_dd = bitlen(OPW_MAX'(in_dividend));
    assign w_len_ds = bitlen(OPW_MAX'(in_divisor));
    // A dividend shorter than the divisor is padded up to the divisor length.
    assign w_m      = (w_len_dd > w_len_ds) ? w_len_dd : w_len_ds;
    assign w_wdata  = {in_dividend, in_divisor, w_m, w_len_ds};

    assign w_pop    = (r_state == S_IDLE) & ~w_empty & done;

    assign w_rd_dd  = w_rdata[JOB_W-1 -: OPW];
    assign w_rd_ds  = w_rdata[2*LEN_W +: OPW];
    assign w_rd_m   = w_rdata[LEN_W +: LEN_W];
    assign w_rd_n   = w_rdata[0 +: LEN_W];

    assign w_count_nxt = CNT_W'(w_count + CNT_W'(w_push) - CNT_W'(w_pop));

    job_fifo #(
        .W     (JOB_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // in_ready is registered from next occupancy so it reads 0 during reset
    // and a pop never frees a slot for a push on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready <= 1'b0;
            r_err_div0 <= 1'b0;
        end else begin
            r_in_ready <= (w_count_nxt != CNT_W'(DEPTH));
            r_err_div0 <= w_div0;
        end
    end

    // Issue FSM with registered divider-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_m        <= '0;
            r_n        <= '0;
            r_jobs     <= '0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_dividend <= DIV_W'(w_rd_dd);
                        r_divisor  <= DIV_W'(w_rd_ds);
                        r_m        <= w_rd_m;
                        r_n        <= w_rd_n;
                        r_ready    <= 1'b1;
                        r_jobs     <= r_jobs + 16'd1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT_DROP;
                end
                // Wait for the divider to acknowledge the start by going busy.
                S_WAIT_DROP: begin
                    if (!done) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign err_div0    = r_err_div0;
    assign dividend    = r_dividend;
    assign divisor     = r_divisor;
    assign m           = r_m;
    assign n           = r_n;
    assign ready       = r_ready;
    assign count       = w_count;
    assign jobs_issued = r_jobs;

endmodule
